// File: rtl/tpic_readback_chk_pkg.sv
// Shared constants, FSM state encoding and helpers for the TPIC readback checker.
package tpic_readback_chk_pkg;

  // Relay frame length: 54 bytes of driver data
  localparam int TPIC_FRAME_W = 432;

  // Width of the per-frame error counter
  localparam int ERR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == {ERR_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/tpic_readback_chk_if.sv
// Bundle of the shifter taps, the SO pin and the checker status outputs.
interface tpic_readback_chk_if
  import tpic_readback_chk_pkg::*;
#(
  parameter int WIDTH = TPIC_FRAME_W
);
  localparam int IDXW = $clog2(WIDTH);

  logic             enable;
  logic [WIDTH-1:0] data;
  logic             sclk;
  logic             rck;
  logic             miso;
  logic             clr_status;
  logic             frame_done;
  logic             ref_valid;
  logic             fault;
  logic             len_err;
  logic [ERR_W-1:0] err_bits;
  logic [IDXW-1:0]  first_err_idx;

  // Checker side
  modport slave (
    input  enable, data, sclk, rck, miso, clr_status,
    output frame_done, ref_valid, fault, len_err, err_bits, first_err_idx
  );

  // Stimulus / monitoring side
  modport master (
    output enable, data, sclk, rck, miso, clr_status,
    input  frame_done, ref_valid, fault, len_err, err_bits, first_err_idx
  );

endinterface

// File: rtl/tpic_readback_chk_sync_edge.sv
// N-flop synchroniser with a rising-edge pulse on the synchronised level.
module tpic_readback_chk_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic sync_o,
  output logic rise_o
);

  logic [STAGES-1:0] chain_q, chain_d;
  logic              prev_q, prev_d;

  // Shift the input down the chain and remember the last synchronised level
  always_comb begin
    chain_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      chain_d[i] = chain_q[i-1];
    end
    prev_d = chain_q[STAGES-1];
  end

  // Synchroniser and edge-history flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
    end
  end

  assign sync_o = chain_q[STAGES-1];
  assign rise_o = chain_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/tpic_readback_chk.sv
// Compares bits returned on the TPIC SO pin against the previously latched frame.
module tpic_readback_chk
  import tpic_readback_chk_pkg::*;
#(
  parameter int WIDTH       = TPIC_FRAME_W,
  parameter int SYNC_STAGES = 2
) (
  input logic                clk,
  input logic                reset_n,
  tpic_readback_chk_if.slave bus
);

  localparam int IDXW = $clog2(WIDTH);
  localparam int CNTW = $clog2(WIDTH + 1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(WIDTH);
  localparam logic [IDXW-1:0] POS_TOP  = IDXW'(WIDTH - 1);

  logic miso_s, miso_rise_unused;
  logic sclk_rise, sclk_lvl_unused;
  logic rck_rise, rck_lvl_unused;

  tpic_readback_chk_sync_edge #(.STAGES(SYNC_STAGES)) u_miso_sync (
    .clk(clk), .reset_n(reset_n), .d(bus.miso), .sync_o(miso_s), .rise_o(miso_rise_unused)
  );
  tpic_readback_chk_sync_edge #(.STAGES(1)) u_sclk_edge (
    .clk(clk), .reset_n(reset_n), .d(bus.sclk), .sync_o(sclk_lvl_unused), .rise_o(sclk_rise)
  );
  tpic_readback_chk_sync_edge #(.STAGES(1)) u_rck_edge (
    .clk(clk), .reset_n(reset_n), .d(bus.rck), .sync_o(rck_lvl_unused), .rise_o(rck_rise)
  );

  state_e           state_q, state_d;
  logic [CNTW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [ERR_W-1:0] work_cnt_q, work_cnt_d;
  logic [IDXW-1:0]  work_idx_q, work_idx_d;
  logic             work_hit_q, work_hit_d;
  logic             frame_done_q, frame_done_d;
  logic             ref_valid_q, ref_valid_d;
  logic             fault_q, fault_d;
  logic             len_err_q, len_err_d;
  logic [ERR_W-1:0] err_bits_q, err_bits_d;
  logic [IDXW-1:0]  first_err_idx_q, first_err_idx_d;

  logic [IDXW-1:0]  bit_pos;
  logic             mismatch;

  // Reference bit for the current position; beyond a full frame nothing is compared
  always_comb begin
    bit_pos  = POS_TOP - bit_cnt_q[IDXW-1:0];
    mismatch = ref_valid_q && (bit_cnt_q != CNT_FULL) && (miso_s != ref_q[bit_pos]);
  end

  // Frame FSM: sample on sclk rise, commit results one cycle after rck rise
  always_comb begin
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    ref_d           = ref_q;
    shadow_d        = shadow_q;
    work_cnt_d      = work_cnt_q;
    work_idx_d      = work_idx_q;
    work_hit_d      = work_hit_q;
    frame_done_d    = 1'b0;
    ref_valid_d     = ref_valid_q;
    fault_d         = fault_q;
    len_err_d       = len_err_q;
    err_bits_d      = err_bits_q;
    first_err_idx_d = first_err_idx_q;

    if (bus.clr_status) begin
      fault_d         = 1'b0;
      len_err_d       = 1'b0;
      err_bits_d      = '0;
      first_err_idx_d = '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.enable) begin
          if (sclk_rise) begin
            // First edge of a frame: capture the data being shifted and restart the tallies
            shadow_d   = bus.data;
            bit_cnt_d  = CNTW'(1);
            work_cnt_d = {{(ERR_W-1){1'b0}}, mismatch};
            work_idx_d = '0;
            work_hit_d = mismatch;
            state_d    = rck_rise ? ST_COMMIT : ST_SHIFT;
          end else if (rck_rise) begin
            state_d = ST_COMMIT;
          end
        end
      end
      ST_SHIFT: begin
        if (!bus.enable) begin
          state_d     = ST_IDLE;
          bit_cnt_d   = '0;
          ref_valid_d = 1'b0;
        end else begin
          if (sclk_rise && (bit_cnt_q != CNT_FULL)) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (mismatch) begin
              work_cnt_d = sat_inc(work_cnt_q);
              if (!work_hit_q) begin
                work_hit_d = 1'b1;
                work_idx_d = bit_cnt_q[IDXW-1:0];
              end
            end
          end
          if (rck_rise) begin
            state_d = ST_COMMIT;
          end
        end
      end
      ST_COMMIT: begin
        frame_done_d = 1'b1;
        state_d      = ST_IDLE;
        bit_cnt_d    = '0;
        if (bit_cnt_q == CNT_FULL) begin
          err_bits_d      = work_cnt_q;
          first_err_idx_d = work_idx_q;
          if (!bus.clr_status) begin
            fault_d = fault_q | (work_cnt_q != '0);
          end
          ref_d       = shadow_q;
          ref_valid_d = 1'b1;
        end else begin
          if (!bus.clr_status) begin
            len_err_d = 1'b1;
            fault_d   = 1'b1;
          end
          ref_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, frame registers and registered status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      bit_cnt_q       <= '0;
      ref_q           <= '0;
      shadow_q        <= '0;
      work_cnt_q      <= '0;
      work_idx_q      <= '0;
      work_hit_q      <= 1'b0;
      frame_done_q    <= 1'b0;
      ref_valid_q     <= 1'b0;
      fault_q         <= 1'b0;
      len_err_q       <= 1'b0;
      err_bits_q      <= '0;
      first_err_idx_q <= '0;
    end else begin
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      ref_q           <= ref_d;
      shadow_q        <= shadow_d;
      work_cnt_q      <= work_cnt_d;
      work_idx_q      <= work_idx_d;
      work_hit_q      <= work_hit_d;
      frame_done_q    <= frame_done_d;
      ref_valid_q     <= ref_valid_d;
      fault_q         <= fault_d;
      len_err_q       <= len_err_d;
      err_bits_q      <= err_bits_d;
      first_err_idx_q <= first_err_idx_d;
    end
  end

  assign bus.frame_done    = frame_done_q;
  assign bus.ref_valid     = ref_valid_q;
  assign bus.fault         = fault_q;
  assign bus.len_err       = len_err_q;
  assign bus.err_bits      = err_bits_q;
  assign bus.first_err_idx = first_err_idx_q;

endmodule
